// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_n.sv
// Sequential shift-add multiplier: one multiplier bit per clock, LSB-first,
// signed operands handled as magnitudes with the sign re-applied at the end.
module seq_multiplier_n
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy
);

    localparam int                CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_t               state, state_next;
    logic [2*WIDTH-1:0]   acc, mcand, acc_sum;
    logic [WIDTH-1:0]     mplier, a_mag, b_mag;
    logic [CNT_W-1:0]     cnt;
    logic                 neg, accept, last_iter;

    // Magnitudes stay WIDTH-bit unsigned, so -2^(WIDTH-1) negates to itself exactly.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        a_mag      = A;
        b_mag      = B;
        if (signed_mode && A[WIDTH-1]) a_mag = -A;
        if (signed_mode && B[WIDTH-1]) b_mag = -B;
        accept     = start && (state != RUN);
        last_iter  = (state == RUN) && (cnt == LAST);
        acc_sum    = mplier[0] ? acc + mcand : acc;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (accept) begin
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a_mag};
            mplier  <= b_mag;
            cnt     <= '0;
            neg     <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
        end else if (state == RUN) begin
            acc     <= acc_sum;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + 1'b1;
            // The final partial sum goes straight to product on the completing edge.
            if (last_iter) product <= neg ? -acc_sum : acc_sum;
        end
    end

    assign done = (state == DONE);
    assign busy = (state == RUN);

endmodule
